// File: rtl/maxnet_input_loader_pkg.sv
// Shared definitions for the maxnet input loader: default geometry and FSM state type.
package maxnet_input_loader_pkg;

    localparam int DATA_W  = 32;
    localparam int N_WORDS = 4;
    localparam int ADDR_W  = $clog2(N_WORDS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/maxnet_input_loader_addr_counter.sv
// Word-address up-counter with synchronous clear, count enable and terminal-count flag.
module maxnet_addr_counter #(
    parameter int WIDTH    = 2,
    parameter int TERMINAL = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic             tc
);

    assign tc = (count == WIDTH'(TERMINAL));

    // The terminal count folds back to 0, so the address idles at 0 after a pass.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= tc ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/maxnet_input_loader.sv
// Loads N_WORDS words from a combinational-read memory, counts the strictly positive ones,
// and holds the set for the downstream maxnet until it is accepted.
module maxnet_input_loader
    import maxnet_input_loader_pkg::*;
#(
    parameter int DATA_W  = maxnet_input_loader_pkg::DATA_W,
    parameter int N_WORDS = maxnet_input_loader_pkg::N_WORDS,
    localparam int ADDR_W = $clog2(N_WORDS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    output logic [ADDR_W-1:0]         mem_address,
    input  logic [DATA_W-1:0]         mem_read_data,
    output logic                      busy,
    output logic [N_WORDS*DATA_W-1:0] x_out,
    output logic [ADDR_W:0]           pos_count,
    output logic                      out_valid,
    input  logic                      out_ready
);

    state_t                         state, state_nxt;
    logic                           accept, rd, last;
    logic [ADDR_W-1:0]              addr;
    logic                           is_pos;
    logic [N_WORDS-1:0][DATA_W-1:0] word_q;

    assign accept = (state == ST_IDLE) && start;
    assign rd     = (state == ST_READ);

    maxnet_addr_counter #(
        .WIDTH    (ADDR_W),
        .TERMINAL (N_WORDS - 1)
    ) u_addr (
        .clk   (clk),
        .rst   (rst),
        .clr   (accept),
        .en    (rd),
        .count (addr),
        .tc    (last)
    );

    assign mem_address = addr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    // start is only looked at in IDLE, so the HOLD->IDLE edge never chains straight into READ.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start)     state_nxt = ST_READ;
            ST_READ: if (last)      state_nxt = ST_HOLD;
            ST_HOLD: if (out_ready) state_nxt = ST_IDLE;
            default:                state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy      = 1'b0;
        out_valid = 1'b0;
        case (state)
            ST_READ: busy = 1'b1;
            ST_HOLD: begin
                busy      = 1'b1;
                out_valid = 1'b1;
            end
            default: ;
        endcase
    end

    generate
        for (genvar i = 0; i < N_WORDS; i++) begin : g_word
            always_ff @(posedge clk or negedge rst) begin
                if (!rst)                          word_q[i] <= '0;
                else if (rd && addr == ADDR_W'(i)) word_q[i] <= mem_read_data;
            end
        end
    endgenerate

    assign x_out = word_q;

    // Strictly positive in two's complement: sign clear and not zero.
    assign is_pos = !mem_read_data[DATA_W-1] && (|mem_read_data);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)        pos_count <= '0;
        else if (accept) pos_count <= '0;
        else if (rd)     pos_count <= pos_count + (ADDR_W+1)'(is_pos);
    end

endmodule

// File: tb/tb_maxnet_input_loader.sv
// Directed bench for maxnet_input_loader: pass timing, hold/handshake, back-to-back, reset abort, sign boundaries.
module tb_maxnet_input_loader;

    localparam int DW = 32;
    localparam int NW = 4;
    localparam int AW = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [AW-1:0]    mem_address;
    logic [DW-1:0]    mem_read_data;
    logic             busy;
    logic [NW*DW-1:0] x_out;
    logic [AW:0]      pos_count;
    logic             out_valid;
    logic             out_ready;

    logic [DW-1:0]    mem [NW];
    int               checks = 0;
    int               errors = 0;

    always #5 clk = ~clk;

    assign mem_read_data = mem[mem_address];

    maxnet_input_loader #(.DATA_W(DW), .N_WORDS(NW)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .mem_address   (mem_address),
        .mem_read_data (mem_read_data),
        .busy          (busy),
        .x_out         (x_out),
        .pos_count     (pos_count),
        .out_valid     (out_valid),
        .out_ready     (out_ready)
    );

    // Inputs change and outputs are sampled on the falling edge.
    task automatic test_reset();
        rst = 1'b0; start = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || mem_address !== '0 ||
            x_out !== '0 || pos_count !== '0) begin
            errors++;
            $display("FAIL reset: valid=%b busy=%b addr=%0d pos=%0d x=%h, need all zero",
                     out_valid, busy, mem_address, pos_count, x_out);
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic_pass();
        logic [NW*DW-1:0] exp_x;
        mem[0] = 32'h0000_0005; mem[1] = 32'hFFFF_FFFE;
        mem[2] = 32'h0000_0000; mem[3] = 32'h0000_007F;
        exp_x = {32'h0000_007F, 32'h0000_0000, 32'hFFFF_FFFE, 32'h0000_0005};
        start = 1'b1;
        for (int e = 0; e < NW; e++) begin
            @(negedge clk);
            start = 1'b0;
            checks++;
            if (mem_address !== AW'(e) || busy !== 1'b1 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL basic_read%0d: addr=%0d busy=%b valid=%b, need addr=%0d busy=1 valid=0",
                         e, mem_address, busy, out_valid, e);
            end
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || busy !== 1'b1 || mem_address !== '0) begin
            errors++;
            $display("FAIL basic_valid: valid=%b busy=%b addr=%0d, need 1 1 0",
                     out_valid, busy, mem_address);
        end
        checks++;
        if (x_out !== exp_x || pos_count !== 3'd2) begin
            errors++;
            $display("FAIL basic_data: x=%h pos=%0d, need x=%h pos=2", x_out, pos_count, exp_x);
        end
    endtask

    task automatic test_hold();
        logic [NW*DW-1:0] exp_x;
        exp_x = {32'h0000_007F, 32'h0000_0000, 32'hFFFF_FFFE, 32'h0000_0005};
        mem[0] = 32'h1111_1111;
        for (int c = 0; c < 10; c++) begin
            start = c[0];
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || x_out !== exp_x || pos_count !== 3'd2) begin
                errors++;
                $display("FAIL hold_cyc%0d: valid=%b pos=%0d x=%h, need valid=1 pos=2 x=%h",
                         c, out_valid, pos_count, x_out, exp_x);
            end
        end
        start = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || x_out !== exp_x || pos_count !== 3'd2) begin
            errors++;
            $display("FAIL hold_release: valid=%b busy=%b pos=%0d x=%h, need 0 0 2 %h",
                     out_valid, busy, pos_count, x_out, exp_x);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_stays: busy=%b valid=%b, need 0 0", busy, out_valid);
        end
    endtask

    // Period of 6 edges: 4 READ, 1 HOLD (handshake), 1 IDLE.
    task automatic test_back_to_back();
        logic [AW-1:0] e_addr;
        logic          e_busy, e_valid;
        mem[0] = 32'h0000_0001; mem[1] = 32'h0000_0002;
        mem[2] = 32'h8000_0003; mem[3] = 32'h0000_0004;
        start = 1'b1; out_ready = 1'b1;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            e_addr = (n % 6 < 4) ? AW'(n % 6) : '0;
            e_busy = (n % 6 != 5);
            e_valid = (n % 6 == 4);
            checks++;
            if (mem_address !== e_addr || busy !== e_busy || out_valid !== e_valid) begin
                errors++;
                $display("FAIL b2b_edge%0d: addr=%0d busy=%b valid=%b, need %0d %b %b",
                         n, mem_address, busy, out_valid, e_addr, e_busy, e_valid);
            end
            if (n % 6 == 4) begin
                checks++;
                if (pos_count !== 3'd3 ||
                    x_out !== {32'h0000_0004, 32'h8000_0003, 32'h0000_0002, 32'h0000_0001}) begin
                    errors++;
                    $display("FAIL b2b_data%0d: pos=%0d x=%h, need pos=3", n, pos_count, x_out);
                end
            end
        end
        start = 1'b0; out_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_abort();
        logic [NW*DW-1:0] exp_x;
        mem[0] = 32'h0000_0009; mem[1] = 32'h0000_000A;
        mem[2] = 32'h0000_000B; mem[3] = 32'h0000_000C;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || mem_address !== '0 ||
            x_out !== '0 || pos_count !== '0) begin
            errors++;
            $display("FAIL abort_now: valid=%b busy=%b addr=%0d pos=%0d x=%h, need all zero",
                     out_valid, busy, mem_address, pos_count, x_out);
        end
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL abort_quiet%0d: valid=%b busy=%b, need 0 0", c, out_valid, busy);
            end
        end
        mem[0] = 32'hDEAD_BEEF; mem[1] = 32'h0000_0010;
        mem[2] = 32'h7FFF_FFFF; mem[3] = 32'h8000_0001;
        exp_x = {32'h8000_0001, 32'h7FFF_FFFF, 32'h0000_0010, 32'hDEAD_BEEF};
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || x_out !== exp_x || pos_count !== 3'd2) begin
            errors++;
            $display("FAIL abort_repass: valid=%b pos=%0d x=%h, need 1 2 %h",
                     out_valid, pos_count, x_out, exp_x);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_pos_bounds();
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < NW; i++) mem[i] = (p == 0) ? 32'h8000_0000 : 32'h0000_0001;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            repeat (4) @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || pos_count !== ((p == 0) ? 3'd0 : 3'd4)) begin
                errors++;
                $display("FAIL pos_bound%0d: valid=%b pos=%0d, need valid=1 pos=%0d",
                         p, out_valid, pos_count, (p == 0) ? 0 : 4);
            end
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
        end
    endtask

    initial begin
        for (int i = 0; i < NW; i++) mem[i] = '0;
        test_reset();
        test_basic_pass();
        test_hold();
        test_back_to_back();
        test_reset_abort();
        test_pos_bounds();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/maxnet_input_loader.md
MAXNET_INPUT_LOADER -- requirements
Module: maxnet_input_loader

Interface
REQ-001 Parameter: DATA_W, default 32, width of one data-memory word.
REQ-002 Parameter: N_WORDS, default 4, words loaded per pass; ADDR_W = clog2(N_WORDS), default 2.
REQ-003 Port: clk  input  1  single clock, all state updates on rising edge.
REQ-004 Port: rst  input  1  reset, asynchronous, active-low.
REQ-005 Port: start  input  1  request one load pass; sampled only in IDLE.
REQ-006 Port: mem_address  output  ADDR_W  word address to the data memory.
REQ-007 Port: mem_read_data  input  DATA_W  combinational read data for mem_address, valid in the same cycle.
REQ-008 Port: busy  output  1  high in READ and HOLD.
REQ-009 Port: x_out  output  N_WORDS*DATA_W  loaded words; word i occupies bits [i*DATA_W +: DATA_W].
REQ-010 Port: pos_count  output  ADDR_W+1  number of loaded words that are signed > 0.
REQ-011 Port: out_valid  output  1  x_out and pos_count are complete and stable.
REQ-012 Port: out_ready  input  1  downstream maxnet accepts the loaded set.

Function
REQ-013 FSM states: IDLE, READ, HOLD. Encoding is free.
REQ-014 IDLE with start=1 at an edge: go to READ, address counter := 0, pos_count := 0. Without start: remain in IDLE.
REQ-015 mem_address is driven directly from the address counter and equals 0 in IDLE and HOLD.
REQ-016 READ, each edge: word[addr] := mem_read_data; pos_count += 1 iff mem_read_data[DATA_W-1]=0 and mem_read_data != 0.
REQ-017 READ: if addr = N_WORDS-1 at the edge, go to HOLD and reset addr to 0; otherwise addr += 1. No wrap-around inside a pass.
REQ-018 Latency: start accepted at edge k; words captured at edges k+1..k+N_WORDS; out_valid is high after edge k+N_WORDS (5 edges for the default).
REQ-019 HOLD: out_valid=1. x_out and pos_count are frozen until handshake.
REQ-020 Handshake: out_valid=1 and out_ready=1 at an edge -> IDLE, out_valid=0. x_out and pos_count retain their values (not cleared).
REQ-021 start is ignored in READ and HOLD, including when start coincides with the HOLD->IDLE handshake edge; a new pass requires start in IDLE.
REQ-022 out_ready is ignored outside HOLD.
REQ-023 Word values are unmodified bit copies; pos_count cannot overflow (max N_WORDS fits in ADDR_W+1 bits).

Reset
REQ-024 rst=0 asynchronously forces: state IDLE, addr 0, mem_address 0, x_out all 0, pos_count 0, out_valid 0, busy 0.
REQ-025 rst asserted mid-READ or in HOLD aborts the pass; partial words are discarded (zeroed), and no out_valid follows.
REQ-026 After rst deasserts, the first start is accepted on the first edge at which rst=1 and start=1.

Structure
REQ-027 The shared maxnet package holds DATA_W, N_WORDS, ADDR_W, and the state enum type.
REQ-028 One sub-module: maxnet_addr_counter (ADDR_W up-counter with clear, enable, terminal-count flag); the FSM and capture registers stay in the top module.

Verification
REQ-029 Memory 0x5,0xFFFFFFFE,0x0,0x7F; pulse start -> mem_address 0,1,2,3 on successive cycles, out_valid after 5 edges, x_out words = those values, pos_count=2.
REQ-030 HOLD with out_ready=0 for 10 cycles -> out_valid stays 1 and x_out stays stable; out_ready=1 -> out_valid=0 on the next edge, state IDLE.
REQ-031 start held high continuously with out_ready=1 -> passes are back-to-back, separated by one IDLE cycle; start during READ/HOLD does not restart the address.
REQ-032 rst pulsed low after the 2nd READ edge -> outputs are immediately zero, no out_valid; a new start produces a full correct pass.
REQ-033 All words 0x80000000 -> pos_count=0; all words 0x00000001 -> pos_count=4 (no overflow).
